// File: rtl/key_debounce_bank.sv
// Purpose : debounce active-low front-panel keys into one-cycle press/repeat pulses.
// Latency : press pulse DEB_CYC+2 edges after the first synchronizer sample of 0.
// Backpres: none; pulses are fire-and-forget, and the consumer must take them when emitted.
//
// Ports:
//   sys_clk    - system clock, rising edge
//   sys_rst_n  - asynchronous active-low reset
//   key_in     - raw buttons, asynchronous, 0 = pressed
//   key_out    - one-cycle press / auto-repeat pulse per key (registered)
//   key_level  - debounced level per key, 1 = held
//   key_long   - 1 while a key is in its auto-repeat phase
module key_debounce_bank #(
   parameter int KEY_W      = 5,
   parameter int DEB_CYC    = 1_000_000,
   parameter int HOLD_CYC   = 25_000_000,
   parameter int REPEAT_CYC = 5_000_000,
   parameter bit REPEAT_EN  = 1'b1
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [KEY_W-1:0] key_in,
   output logic [KEY_W-1:0] key_out,
   output logic [KEY_W-1:0] key_level,
   output logic [KEY_W-1:0] key_long
);

   localparam int HOLD_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
   localparam int CNT_W    = (DEB_CYC  > 1) ? $clog2(DEB_CYC)  : 1;
   localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

   localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYC - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRESS = 2'd1;
   localparam logic [1:0] ST_DOWN  = 2'd2;
   localparam logic [1:0] ST_REL   = 2'd3;

   // Two-flop synchronizer. Reset to all 1s (released) so a key held
   // through reset still has to pass the full press filter.
   logic [KEY_W-1:0] r_sync1;
   logic [KEY_W-1:0] r_sync2;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= key_in;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
      logic [1:0]        r_state;
      logic [CNT_W-1:0]  r_cnt;
      logic [HOLD_W-1:0] r_hold;
      logic              r_rep;
      logic              r_out;
      logic              r_level;
      logic              r_long;
      logic              w_pressed;
      logic [HOLD_W-1:0] w_hold_last;

      assign w_pressed   = ~r_sync2[gi];
      // First repeat waits the long hold time, later ones the short period.
      assign w_hold_last = r_rep ? REP_LAST : HOLD_LAST;

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_rep   <= 1'b0;
            r_out   <= 1'b0;
            r_level <= 1'b0;
            r_long  <= 1'b0;
         end else begin
            r_out <= 1'b0;
            case (r_state)
               ST_IDLE: begin
                  if (w_pressed) begin
                     r_state <= ST_PRESS;
                     r_cnt   <= '0;
                  end
               end
               ST_PRESS: begin
                  if (!w_pressed) begin
                     r_state <= ST_IDLE;
                  end else if (r_cnt == DEB_LAST) begin
                     r_state <= ST_DOWN;
                     r_out   <= 1'b1;
                     r_level <= 1'b1;
                     r_hold  <= '0;
                     r_rep   <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               ST_DOWN: begin
                  // A release sample takes priority over a repeat that
                  // would otherwise fall due on the same edge.
                  if (!w_pressed) begin
                     r_state <= ST_REL;
                     r_cnt   <= '0;
                  end else if (REPEAT_EN) begin
                     if (r_hold == w_hold_last) begin
                        r_out  <= 1'b1;
                        r_hold <= '0;
                        r_rep  <= 1'b1;
                        r_long <= 1'b1;
                     end else begin
                        r_hold <= r_hold + 1'b1;
                     end
                  end
               end
               ST_REL: begin
                  // A glitch back to pressed restarts only the repeat timer;
                  // repeat phase and key_long survive it.
                  if (w_pressed) begin
                     r_state <= ST_DOWN;
                     r_hold  <= '0;
                  end else if (r_cnt == DEB_LAST) begin
                     r_state <= ST_IDLE;
                     r_level <= 1'b0;
                     r_long  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end

      assign key_out[gi]   = r_out;
      assign key_level[gi] = r_level;
      assign key_long[gi]  = r_long;
   end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Purpose : table-driven and hand-sequenced checks of key_debounce_bank.
// Latency : outputs sampled on the falling edge after each rising edge.
// Backpres: not applicable.
module tb_key_debounce_bank;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [4:0] key_in    = 5'b11110;
   logic [4:0] out_r, lvl_r, long_r;
   logic [4:0] out_n, lvl_n, long_n;

   int n_chk  = 0;
   int n_pass = 0;

   int pulses_n, pulses_r, pulse_at, long_seen, fall_at;

   always #5 sys_clk = ~sys_clk;

   key_debounce_bank #(
      .KEY_W(5), .DEB_CYC(4), .HOLD_CYC(10), .REPEAT_CYC(3), .REPEAT_EN(1'b1)
   ) u_dut_rep (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
      .key_out(out_r), .key_level(lvl_r), .key_long(long_r)
   );

   key_debounce_bank #(
      .KEY_W(5), .DEB_CYC(4), .HOLD_CYC(10), .REPEAT_CYC(3), .REPEAT_EN(1'b0)
   ) u_dut_nr (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
      .key_out(out_n), .key_level(lvl_n), .key_long(long_n)
   );

   // One record = key_in held for n cycles, outputs expected constant
   // on every one of those cycles (repeat-enabled instance).
   typedef struct {
      logic [4:0] ki;
      int         n;
      logic [4:0] eo;
      logic [4:0] el;
      logic [4:0] eg;
   } seg_t;

   seg_t tbl[$];

   task automatic add(input logic [4:0] ki, input int n,
                      input logic [4:0] eo, input logic [4:0] el, input logic [4:0] eg);
      seg_t s;
      s.ki = ki; s.n = n; s.eo = eo; s.el = el; s.eg = eg;
      tbl.push_back(s);
   endtask

   task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b want %b", name, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   task automatic cyc(input logic [4:0] ki);
      key_in = ki;
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   initial begin
      // ---- reset state, key 0 held through reset ----
      sys_rst_n = 1'b0;
      key_in    = 5'b11110;
      repeat (3) @(negedge sys_clk);
      check("reset_rep", {out_r, lvl_r, long_r}, 15'd0);
      check("reset_nr",  {out_n, lvl_n, long_n}, 15'd0);

      // Reset hold: pulse 6 edges after the first sampling edge (edge 1).
      add(5'b11110, 6, 5'b00000, 5'b00000, 5'b00000);
      add(5'b11110, 1, 5'b00001, 5'b00001, 5'b00000);
      add(5'b11111, 6, 5'b00000, 5'b00001, 5'b00000);
      add(5'b11111, 3, 5'b00000, 5'b00000, 5'b00000);
      // Bounce reject on key 2.
      add(5'b11011, 3, 5'b00000, 5'b00000, 5'b00000);
      add(5'b11111, 8, 5'b00000, 5'b00000, 5'b00000);
      // Auto-repeat on key 3: k+6, k+16, k+19, k+22; release at k+23.
      add(5'b10111, 6, 5'b00000, 5'b00000, 5'b00000);
      add(5'b10111, 1, 5'b01000, 5'b01000, 5'b00000);
      add(5'b10111, 9, 5'b00000, 5'b01000, 5'b00000);
      add(5'b10111, 1, 5'b01000, 5'b01000, 5'b01000);
      add(5'b10111, 2, 5'b00000, 5'b01000, 5'b01000);
      add(5'b10111, 1, 5'b01000, 5'b01000, 5'b01000);
      add(5'b10111, 2, 5'b00000, 5'b01000, 5'b01000);
      add(5'b10111, 1, 5'b01000, 5'b01000, 5'b01000);
      add(5'b11111, 6, 5'b00000, 5'b01000, 5'b01000);
      add(5'b11111, 3, 5'b00000, 5'b00000, 5'b00000);
      // Simultaneous press of all keys.
      add(5'b00000, 6, 5'b00000, 5'b00000, 5'b00000);
      add(5'b00000, 1, 5'b11111, 5'b11111, 5'b00000);
      add(5'b11111, 6, 5'b00000, 5'b11111, 5'b00000);
      add(5'b11111, 3, 5'b00000, 5'b00000, 5'b00000);
      // Release glitch on key 4: repeat timer restarts, first repeat at k+25.
      add(5'b01111, 6,  5'b00000, 5'b00000, 5'b00000);
      add(5'b01111, 1,  5'b10000, 5'b10000, 5'b00000);
      add(5'b01111, 4,  5'b00000, 5'b10000, 5'b00000);
      add(5'b11111, 2,  5'b00000, 5'b10000, 5'b00000);
      add(5'b01111, 12, 5'b00000, 5'b10000, 5'b00000);
      add(5'b01111, 1,  5'b10000, 5'b10000, 5'b10000);
      add(5'b11111, 6,  5'b00000, 5'b10000, 5'b10000);
      add(5'b11111, 3,  5'b00000, 5'b00000, 5'b00000);

      sys_rst_n = 1'b1;
      for (int r = 0; r < tbl.size(); r++) begin
         for (int c = 0; c < tbl[r].n; c++) begin
            cyc(tbl[r].ki);
            check($sformatf("row%0d_cyc%0d", r, c), {out_r, lvl_r, long_r},
                  {tbl[r].eo, tbl[r].el, tbl[r].eg});
         end
      end

      // ---- clean press/release on key 1, repeat disabled ----
      pulses_n = 0; pulses_r = 0; pulse_at = -1; long_seen = 0; fall_at = -1;
      for (int i = 0; i < 40; i++) begin
         cyc(5'b11101);
         if (out_n[1]) begin
            pulses_n++;
            if (pulse_at < 0) pulse_at = i;
         end
         if (out_r[1]) pulses_r++;
         if (long_n[1]) long_seen = 1;
      end
      check_int("norep_pulse_count", pulses_n, 1);
      check_int("norep_pulse_edge", pulse_at, 6);
      check_int("norep_long_never", long_seen, 0);
      check_int("rep_pulse_count_40", pulses_r, 9);
      check("norep_level_held", {10'd0, lvl_n}, 15'b000000000000010);
      for (int i = 0; i < 10; i++) begin
         cyc(5'b11111);
         if (!lvl_n[1] && fall_at < 0) fall_at = i;
      end
      check_int("norep_release_edge", fall_at, 6);

      // ---- reset mid-operation, key 2 held through it ----
      for (int i = 0; i < 8; i++) cyc(5'b11011);
      check("midrst_pre_level", {10'd0, lvl_r}, 15'b000000000000100);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("midrst_async_rep", {out_r, lvl_r, long_r}, 15'd0);
      check("midrst_async_nr",  {out_n, lvl_n, long_n}, 15'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cyc(5'b11011);
         if (i < 6) begin
            check($sformatf("midrst_quiet_rep%0d", i), {out_r, lvl_r, long_r}, 15'd0);
            check($sformatf("midrst_quiet_nr%0d", i),  {out_n, lvl_n, long_n}, 15'd0);
         end else begin
            check("midrst_pulse_rep", {out_r, lvl_r, long_r}, {5'b00100, 5'b00100, 5'b00000});
            check("midrst_pulse_nr",  {out_n, lvl_n, long_n}, {5'b00100, 5'b00100, 5'b00000});
         end
      end
      for (int i = 0; i < 8; i++) cyc(5'b11111);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
